// File: rtl/eyeriss_pe_row_scheduler_if.sv
// Signal bundle between the Eyeriss PE row scheduler (master) and its job source, fetch units, PE row and psum sink (slave).
interface eyeriss_pe_row_scheduler_if #(
  parameter int IMG_WIDTH = 32,
  parameter int ROW_CNT_W = 8
);
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic                 i_job_valid;
  logic                 o_job_ready;
  logic [ROW_CNT_W-1:0] i_job_rows;
  logic                 o_wgt_req;
  logic                 i_wgt_ack;
  logic                 o_spk_req;
  logic                 i_spk_ack;
  logic                 o_pe_weight_valid;
  logic                 o_pe_spikes_valid;
  logic                 o_pe_cal_start;
  logic                 o_psum_valid;
  logic                 i_psum_ready;
  logic [COL_W-1:0]     o_col_idx;
  logic [ROW_CNT_W-1:0] o_row_idx;
  logic                 o_job_done;

  modport master (
    input  i_job_valid, i_job_rows, i_wgt_ack, i_spk_ack, i_psum_ready,
    output o_job_ready, o_wgt_req, o_spk_req, o_pe_weight_valid, o_pe_spikes_valid,
           o_pe_cal_start, o_psum_valid, o_col_idx, o_row_idx, o_job_done
  );

  modport slave (
    output i_job_valid, i_job_rows, i_wgt_ack, i_spk_ack, i_psum_ready,
    input  o_job_ready, o_wgt_req, o_spk_req, o_pe_weight_valid, o_pe_spikes_valid,
           o_pe_cal_start, o_psum_valid, o_col_idx, o_row_idx, o_job_done
  );
endinterface

// File: rtl/eyeriss_pe_row_scheduler.sv
// Sequences weight load, spike-line load and IMG_WIDTH compute steps per output row of a job.
// Define ERS_SCHED_WEIGHT_REUSE_EN to fetch weights only for the first row of each job.
module eyeriss_pe_row_scheduler #(
  parameter int IMG_WIDTH = 32,
  parameter int ROW_CNT_W = 8
) (
  input logic                         s_clk,
  input logic                         s_rst,
  eyeriss_pe_row_scheduler_if.master  bus
);
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_S,
    CALC,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [ROW_CNT_W-1:0] rows_total;
  logic [ROW_CNT_W-1:0] row_cnt;
  logic [COL_W-1:0]     col_cnt;
  logic [COL_W-1:0]     col_idx;
  logic [ROW_CNT_W-1:0] row_idx;
  logic                 psum_valid;

  logic job_ready, wgt_req, spk_req, weight_valid, spikes_valid, cal_start, job_done;
  logic job_accept, row_advance, stall, psum_accept, last_row;

  assign stall       = psum_valid && !bus.i_psum_ready;
  assign psum_accept = psum_valid && bus.i_psum_ready;
  assign last_row    = (row_cnt == rows_total - ROW_CNT_W'(1));

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next   = state;
    job_ready    = 1'b0;
    wgt_req      = 1'b0;
    spk_req      = 1'b0;
    weight_valid = 1'b0;
    spikes_valid = 1'b0;
    cal_start    = 1'b0;
    job_done     = 1'b0;
    job_accept   = 1'b0;
    row_advance  = 1'b0;
    unique case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (bus.i_job_valid) begin
          job_accept = 1'b1;
          state_next = (bus.i_job_rows == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        wgt_req = 1'b1;
        if (bus.i_wgt_ack) begin
          weight_valid = 1'b1;
          state_next   = LOAD_S;
        end
      end
      LOAD_S: begin
        spk_req = 1'b1;
        if (bus.i_spk_ack) begin
          spikes_valid = 1'b1;
          state_next   = CALC;
        end
      end
      CALC: begin
        cal_start = !stall;
        if (cal_start && col_cnt == LAST_COL) state_next = DRAIN;
      end
      DRAIN: begin
        if (psum_accept) begin
          if (last_row) begin
            state_next = DONE;
          end else begin
            row_advance = 1'b1;
`ifdef ERS_SCHED_WEIGHT_REUSE_EN
            state_next  = LOAD_S;
`else
            state_next  = LOAD_W;
`endif
          end
        end
      end
      DONE: begin
        job_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      rows_total <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      psum_valid <= 1'b0;
      col_idx    <= '0;
      row_idx    <= '0;
    end else begin
      if (job_accept) begin
        rows_total <= bus.i_job_rows;
        row_cnt    <= '0;
      end else if (row_advance) begin
        row_cnt <= row_cnt + ROW_CNT_W'(1);
      end

      if (spikes_valid)   col_cnt <= '0;
      else if (cal_start) col_cnt <= col_cnt + COL_W'(1);

      // PE has one cycle of latency; a fresh result overrides a same-cycle accept.
      if (cal_start) begin
        psum_valid <= 1'b1;
        col_idx    <= col_cnt;
        row_idx    <= row_cnt;
      end else if (psum_accept) begin
        psum_valid <= 1'b0;
      end
    end
  end

  assign bus.o_job_ready       = job_ready;
  assign bus.o_wgt_req         = wgt_req;
  assign bus.o_spk_req         = spk_req;
  assign bus.o_pe_weight_valid = weight_valid;
  assign bus.o_pe_spikes_valid = spikes_valid;
  assign bus.o_pe_cal_start    = cal_start;
  assign bus.o_psum_valid      = psum_valid;
  assign bus.o_col_idx         = col_idx;
  assign bus.o_row_idx         = row_idx;
  assign bus.o_job_done        = job_done;
endmodule

// File: tb/tb_eyeriss_pe_row_scheduler.sv
// Self-checking bench for eyeriss_pe_row_scheduler: table of jobs checked against a psum scoreboard,
// plus hand sequences for reset, zero-row jobs and mid-job reset.
module tb_eyeriss_pe_row_scheduler;
  localparam int IMG_WIDTH = 32;
  localparam int ROW_CNT_W = 8;
  localparam int COL_W     = 5;
`ifdef ERS_SCHED_WEIGHT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic s_clk = 1'b0;
  logic s_rst = 1'b1;

  eyeriss_pe_row_scheduler_if #(.IMG_WIDTH(IMG_WIDTH), .ROW_CNT_W(ROW_CNT_W)) bus ();

  eyeriss_pe_row_scheduler #(.IMG_WIDTH(IMG_WIDTH), .ROW_CNT_W(ROW_CNT_W)) dut (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  always #5 s_clk = ~s_clk;

  typedef struct packed {
    logic [ROW_CNT_W-1:0] row;
    logic [COL_W-1:0]     col;
  } psum_t;

  typedef struct {
    int rows;
    int stall_col;
    int exp_wgt;
    int exp_spk;
    int exp_stall;
  } vec_t;

  psum_t sb_q[$];
  psum_t sb_exp;
  vec_t  vecs[4];

  int checks = 0;
  int errors = 0;
  int n_cal, n_psum, n_wgt_ep, n_spk_ep, n_wstb, n_sstb, n_done, n_dbl_done, n_overlap, n_stall;
  logic prev_wreq = 1'b0, prev_sreq = 1'b0, prev_done = 1'b0;
  int stall_col   = -1;
  bit stall_armed = 1'b0;
  int stall_left  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_cal = 0; n_psum = 0; n_wgt_ep = 0; n_spk_ep = 0; n_wstb = 0;
    n_sstb = 0; n_done = 0; n_dbl_done = 0; n_overlap = 0; n_stall = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wgt_req"},      bus.o_wgt_req, 0);
    check({tag, "_spk_req"},      bus.o_spk_req, 0);
    check({tag, "_weight_valid"}, bus.o_pe_weight_valid, 0);
    check({tag, "_spikes_valid"}, bus.o_pe_spikes_valid, 0);
    check({tag, "_cal_start"},    bus.o_pe_cal_start, 0);
    check({tag, "_psum_valid"},   bus.o_psum_valid, 0);
    check({tag, "_col_idx"},      bus.o_col_idx, 0);
    check({tag, "_row_idx"},      bus.o_row_idx, 0);
    check({tag, "_job_done"},     bus.o_job_done, 0);
  endtask

  // Monitor: samples 3 time units after the falling edge, well clear of the rising edge.
  initial begin
    clear_stats();
    forever begin
      @(negedge s_clk);
      #3;
      if (!s_rst) begin
        if (bus.o_wgt_req && !prev_wreq) n_wgt_ep++;
        if (bus.o_spk_req && !prev_sreq) n_spk_ep++;
        if (bus.o_wgt_req && bus.o_spk_req) n_overlap++;
        if (bus.o_pe_weight_valid) n_wstb++;
        if (bus.o_pe_spikes_valid) n_sstb++;
        if (bus.o_pe_cal_start) n_cal++;
        if (bus.o_job_done) begin
          n_done++;
          if (prev_done) n_dbl_done++;
        end
        if (bus.o_psum_valid && !bus.i_psum_ready) begin
          n_stall++;
          check("stall_halt", bus.o_pe_cal_start, 0);
          if (stall_col >= 0) check("stall_col_hold", bus.o_col_idx, stall_col);
        end
        if (bus.o_psum_valid && bus.i_psum_ready) begin
          n_psum++;
          if (sb_q.size() == 0) begin
            check("psum_spurious", {bus.o_row_idx, bus.o_col_idx}, 32'hFFFF_FFFF);
          end else begin
            sb_exp = sb_q.pop_front();
            check("psum_idx", {bus.o_row_idx, bus.o_col_idx}, sb_exp);
          end
        end
      end
      prev_wreq = bus.o_wgt_req;
      prev_sreq = bus.o_spk_req;
      prev_done = bus.o_job_done;
    end
  end

  // Weight fetch unit: acks on the second cycle of each request.
  initial begin : wgt_resp
    int w;
    w = 0;
    bus.i_wgt_ack = 1'b0;
    forever begin
      @(negedge s_clk);
      bus.i_wgt_ack = 1'b0;
      if (bus.o_wgt_req && !s_rst) begin
        w++;
        if (w == 2) begin
          bus.i_wgt_ack = 1'b1;
          w = 0;
        end
      end else begin
        w = 0;
      end
    end
  end

  initial begin : spk_resp
    int w;
    w = 0;
    bus.i_spk_ack = 1'b0;
    forever begin
      @(negedge s_clk);
      bus.i_spk_ack = 1'b0;
      if (bus.o_spk_req && !s_rst) begin
        w++;
        if (w == 2) begin
          bus.i_spk_ack = 1'b1;
          w = 0;
        end
      end else begin
        w = 0;
      end
    end
  end

  // Psum sink: always ready, except a 5-cycle back-pressure when the armed column of row 0 appears.
  initial begin
    bus.i_psum_ready = 1'b1;
    forever begin
      @(negedge s_clk);
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bus.i_psum_ready = 1'b1;
      end else if (stall_armed && bus.o_psum_valid && bus.o_row_idx == 0 && bus.o_col_idx == stall_col) begin
        stall_armed      = 1'b0;
        bus.i_psum_ready = 1'b0;
        stall_left       = 5;
      end
    end
  end

  task automatic start_job(input int rows);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < IMG_WIDTH; c++)
        sb_q.push_back(psum_t'{row: ROW_CNT_W'(r), col: COL_W'(c)});
    @(negedge s_clk);
    check("job_ready_idle", bus.o_job_ready, 1);
    bus.i_job_valid = 1'b1;
    bus.i_job_rows  = ROW_CNT_W'(rows);
    @(negedge s_clk);
    bus.i_job_valid = 1'b0;
    bus.i_job_rows  = '1;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge s_clk);
      #4;
      if (n_done > 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_within_budget", seen, 1);
  endtask

  task automatic run_job(input int rows, input int scol);
    clear_stats();
    stall_col   = scol;
    stall_armed = (scol >= 0);
    start_job(rows);
    wait_done(4000);
    repeat (3) @(negedge s_clk);
    stall_col = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.i_job_valid = 1'b0;
    bus.i_job_rows  = '0;
    vecs[0] = '{rows: 1, stall_col: -1, exp_wgt: 1,              exp_spk: 1, exp_stall: 0};
    vecs[1] = '{rows: 3, stall_col: -1, exp_wgt: REUSE ? 1 : 3, exp_spk: 3, exp_stall: 0};
    vecs[2] = '{rows: 2, stall_col: 10, exp_wgt: REUSE ? 1 : 2, exp_spk: 2, exp_stall: 5};
    vecs[3] = '{rows: 0, stall_col: -1, exp_wgt: 0,              exp_spk: 0, exp_stall: 0};

    // Reset state while reset is held and after release.
    #2;
    check_reset_outputs("rst");
    check("rst_job_ready", bus.o_job_ready, 1);
    @(negedge s_clk);
    s_rst = 1'b0;
    @(negedge s_clk);
    #3;
    check("post_rst_job_ready", bus.o_job_ready, 1);

    for (int i = 0; i < 4; i++) begin
      run_job(vecs[i].rows, vecs[i].stall_col);
      check($sformatf("v%0d_psums", i),        n_psum,      vecs[i].rows * IMG_WIDTH);
      check($sformatf("v%0d_cal_starts", i),   n_cal,       vecs[i].rows * IMG_WIDTH);
      check($sformatf("v%0d_wgt_episodes", i), n_wgt_ep,    vecs[i].exp_wgt);
      check($sformatf("v%0d_wgt_strobes", i),  n_wstb,      vecs[i].exp_wgt);
      check($sformatf("v%0d_spk_episodes", i), n_spk_ep,    vecs[i].exp_spk);
      check($sformatf("v%0d_spk_strobes", i),  n_sstb,      vecs[i].exp_spk);
      check($sformatf("v%0d_done_pulses", i),  n_done,      1);
      check($sformatf("v%0d_done_width", i),   n_dbl_done,  0);
      check($sformatf("v%0d_req_overlap", i),  n_overlap,   0);
      check($sformatf("v%0d_stall_cycles", i), n_stall,     vecs[i].exp_stall);
      check($sformatf("v%0d_sb_drained", i),   sb_q.size(), 0);
    end

    // Zero-row job: done exactly one cycle after accept, no fetches.
    clear_stats();
    @(negedge s_clk);
    bus.i_job_valid = 1'b1;
    bus.i_job_rows  = '0;
    @(negedge s_clk);
    bus.i_job_valid = 1'b0;
    #3;
    check("rows0_done_latency", bus.o_job_done, 1);
    check("rows0_busy", bus.o_job_ready, 0);
    @(negedge s_clk);
    #3;
    check("rows0_done_one_cycle", bus.o_job_done, 0);
    check("rows0_back_idle", bus.o_job_ready, 1);
    check("rows0_no_wgt_req", n_wgt_ep, 0);
    check("rows0_no_spk_req", n_spk_ep, 0);

    // Reset in the middle of row 1, column 15.
    clear_stats();
    start_job(2);
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge s_clk);
      #2;
      if (bus.o_psum_valid && bus.o_row_idx == 1 && bus.o_col_idx == 15) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_point_reached", found, 1);
    s_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_job_ready", bus.o_job_ready, 1);
    @(negedge s_clk);
    s_rst = 1'b0;
    sb_q.delete();
    clear_stats();
    repeat (4) @(negedge s_clk);
    check("midrst_no_done", n_done, 0);
    check("midrst_idle_ready", bus.o_job_ready, 1);
    run_job(1, -1);
    check("after_rst_psums", n_psum, IMG_WIDTH);
    check("after_rst_done", n_done, 1);
    check("after_rst_sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eyeriss_pe_row_scheduler.md
EYERISS_PE_ROW_SCHEDULER -- requirements
Module: eyeriss_pe_row_scheduler

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 32: spike columns per line and cal_start pulses per output row.
REQ-002 SHALL have parameter ROW_CNT_W, default 8: width of the job row count.
REQ-003 SHALL have port s_clk, input, 1: clock.
REQ-004 SHALL have port s_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_job_valid, input, 1: job request.
REQ-006 SHALL have port o_job_ready, output, 1: scheduler idle and accepting a job.
REQ-007 SHALL have port i_job_rows, input, ROW_CNT_W: output rows in the job, sampled at job accept.
REQ-008 SHALL have port o_wgt_req, output, 1: weight-fetch request, level.
REQ-009 SHALL have port i_wgt_ack, input, 1: weights present on the PE weight bus.
REQ-010 SHALL have port o_spk_req, output, 1: spike-line fetch request, level.
REQ-011 SHALL have port i_spk_ack, input, 1: spike line present on the PE spike bus.
REQ-012 SHALL have port o_pe_weight_valid, output, 1: PE weight strobe.
REQ-013 SHALL have port o_pe_spikes_valid, output, 1: PE spike-load strobe.
REQ-014 SHALL have port o_pe_cal_start, output, 1: PE compute/shift enable.
REQ-015 SHALL have port o_psum_valid, output, 1: PE psum outputs hold a new column result.
REQ-016 SHALL have port i_psum_ready, input, 1: downstream accepts the psum.
REQ-017 SHALL have port o_col_idx, output, clog2(IMG_WIDTH): column index of the presented psum.
REQ-018 SHALL have port o_row_idx, output, ROW_CNT_W: row index of the presented psum.
REQ-019 SHALL have port o_job_done, output, 1: one-cycle pulse when the job completes.

Function
REQ-020 SHALL implement states IDLE, LOAD_W, LOAD_S, CALC, DRAIN, DONE.
REQ-021 SHALL assert o_job_ready only in IDLE; job accepted on i_job_valid && o_job_ready.
- Rows = 0: go to DONE.
- Rows > 0: go to LOAD_W, row counter = 0.
REQ-022 SHALL hold o_wgt_req high throughout LOAD_W.
- On i_wgt_ack: pulse o_pe_weight_valid for exactly one cycle (the ack cycle), go to LOAD_S.
- Strobe deasserts for at least one cycle between rows, so the PE sees a fresh rising edge.
REQ-023 SHALL hold o_spk_req high throughout LOAD_S.
- On i_spk_ack: pulse o_pe_spikes_valid for one cycle, column counter = 0, go to CALC.
REQ-024 SHALL drive o_pe_cal_start = (state==CALC) && !stall, where stall = o_psum_valid && !i_psum_ready.
REQ-025 SHALL set o_psum_valid the cycle after each o_pe_cal_start (PE latency 1).
- Holds until accepted (o_psum_valid && i_psum_ready) with no new cal_start in that cycle.
- Accept and new cal_start in the same cycle: o_psum_valid stays high.
REQ-026 SHALL register o_col_idx / o_row_idx with o_psum_valid; stable while valid && !ready.
REQ-027 SHALL issue exactly IMG_WIDTH cal_start pulses per row, then go to DRAIN.
REQ-028 SHALL leave DRAIN when the last psum is accepted.
- More rows remain: go to LOAD_W with row counter + 1.
- Otherwise: go to DONE.
REQ-029 SHALL pulse o_job_done for one cycle in DONE, then return to IDLE.
REQ-030 SHALL ignore acks outside their own state and never assert o_wgt_req and o_spk_req together.
REQ-031 SHALL ignore i_job_valid outside IDLE.

Reset
REQ-032 SHALL, on s_rst, asynchronously enter IDLE, clear all counters, and drive every output 0 except o_job_ready, which SHALL be 1 once reset deasserts.
REQ-033 SHALL abandon any in-flight job on reset mid-operation; no o_job_done is issued for the abandoned job.

Configuration
REQ-034 SHALL support macro ERS_SCHED_WEIGHT_REUSE_EN.
- Defined: LOAD_W is visited only for row 0 of a job; later rows go DRAIN -> LOAD_S and reuse the PE weights.
- Undefined: LOAD_W is visited for every row.

Verification
REQ-035 SHALL cover: rows=1, acks after 2 cycles, ready always 1 -> 32 cal_start pulses, 32 psum_valid with col 0..31, one done pulse.
REQ-036 SHALL cover: rows=3, reuse macro undefined -> 3 o_wgt_req episodes and 3 o_spk_req episodes; row_idx 0..2; 96 psums.
REQ-037 SHALL cover: rows=3, macro defined -> 1 o_wgt_req episode, 3 o_spk_req episodes, 96 psums.
REQ-038 SHALL cover: i_psum_ready low for 5 cycles at col 10 -> cal_start halts; col_idx holds 10; no psum lost or duplicated.
REQ-039 SHALL cover: rows=0 -> done pulse 1 cycle after accept; no requests issued.
REQ-040 SHALL cover: s_rst asserted at col 15 of row 1 -> outputs 0 immediately; after release o_job_ready=1 and a new job completes normally.
